// File: rtl/addtree_pkg.sv
// Shared widths, constants and state encoding for the adder-tree pipeline driver.
package addtree_pkg;
    localparam int OP_W  = 30;
    localparam int SUM_W = 33;

    localparam logic [15:0]     K0        = 16'hFFFF;
    localparam logic [15:0]     K1        = 16'hABCD;
    localparam logic [OP_W-1:0] LFSR_TAPS = 30'h2000_0029;  // x^30 + x^6 + x^4 + x + 1
    localparam logic [1:0]      SEL_HOLD  = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    // Constant contribution of the pipeline's second stage: 2*K.
    function automatic logic [SUM_W-1:0] k_term(input logic s);
        return {16'b0, (s ? K1 : K0), 1'b0};
    endfunction
endpackage

// File: rtl/addtree_driver_if.sv
// Operand/select bus towards the adder-tree pipeline and its returned sum.
interface addtree_driver_if;
    import addtree_pkg::*;

    logic [OP_W-1:0] in1, in2, in3, in4;
    logic [1:0]      sel;
    logic [31:0]     result;
    logic            carry;

    modport master (output in1, in2, in3, in4, sel, input result, carry);
    modport slave  (input in1, in2, in3, in4, sel, output result, carry);
endinterface

// File: rtl/addtree_lfsr30.sv
// 30-bit Fibonacci LFSR; a zero seed is replaced by 1 so the sequence never locks up.
module addtree_lfsr30
    import addtree_pkg::*;
(
    input  logic            sysclk,
    input  logic            rst,
    input  logic            load,
    input  logic            advance,
    input  logic [OP_W-1:0] seed,
    output logic [OP_W-1:0] state
);
    always_ff @(posedge sysclk) begin
        if (rst)
            state <= OP_W'(1);
        else if (load)
            state <= (seed == '0) ? OP_W'(1) : seed;
        else if (advance)
            state <= {state[OP_W-2:0], ^(state & LFSR_TAPS)};
    end
endmodule

// File: rtl/addtree_driver.sv
// Drives test vectors into a 2-stage adder-tree pipeline and checks the returned sums.
module addtree_driver
    import addtree_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   count,
    input  logic [OP_W-1:0]    seed,
    input  logic               pat_mode,
    input  logic [1:0]         sel_mode,
    addtree_driver_if.master   pipe,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]   first_err_idx
);
    state_t state, nxt;

    logic             accept, issue, last, drain_cnt, mismatch;
    logic [CNT_W-1:0] cnt_q, idx;
    logic             pat_q;
    logic [1:0]       smode_q;
    logic [OP_W-1:0]  lfsr;
    logic [OP_W-1:0]  op1, op2, op3, op4;
    logic             sel_now, sel_a;
    logic [SUM_W-1:0] exp_now;

    // Stage 1 lines up with the pipeline's sel stage, stage 2 with its output.
    logic [2:1]                  vld_pipe;
    logic [2:1][SUM_W-1:0]       exp_pipe;
    logic [2:1][CNT_W-1:0]       idx_pipe;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (idx == cnt_q - CNT_W'(1));

    always_ff @(posedge sysclk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (start) nxt = (count == '0) ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: if (last) nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE);
        issue = (state == ST_ISSUE);
    end

    addtree_lfsr30 u_lfsr (
        .sysclk  (sysclk),
        .rst     (rst),
        .load    (accept),
        .advance (issue),
        .seed    (seed),
        .state   (lfsr)
    );

    always_comb begin
        op1     = '0;
        op2     = '0;
        op3     = '0;
        op4     = '0;
        sel_now = 1'b0;
        if (issue) begin
            if (pat_q) begin
                op1 = '1;
                op2 = '1;
                op3 = '1;
                op4 = '1;
            end else begin
                op1 = lfsr;
                op2 = {lfsr[14:0], lfsr[29:15]};
                op3 = ~lfsr;
                op4 = lfsr ^ OP_W'(idx);
            end
            case (smode_q)
                2'd0: sel_now = 1'b0;
                2'd1: sel_now = 1'b1;
                2'd2: sel_now = idx[0];
                default: sel_now = lfsr[0];
            endcase
        end
    end

    assign exp_now = SUM_W'(op1) + SUM_W'(op2) + SUM_W'(op3) + SUM_W'(op4) + k_term(sel_now);

    assign pipe.in1 = op1;
    assign pipe.in2 = op2;
    assign pipe.in3 = op3;
    assign pipe.in4 = op4;
    assign pipe.sel = vld_pipe[1] ? {1'b0, sel_a} : SEL_HOLD;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], issue};
        end
        exp_pipe <= {exp_pipe[1], exp_now};
        idx_pipe <= {idx_pipe[1], idx};
        sel_a    <= sel_now;
    end

    assign mismatch = vld_pipe[2] && ({pipe.carry, pipe.result} != exp_pipe[2]);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx           <= '0;
            pat_q         <= 1'b0;
            smode_q       <= 2'd0;
            drain_cnt     <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else if (accept) begin
            cnt_q         <= count;
            idx           <= '0;
            pat_q         <= pat_mode;
            smode_q       <= sel_mode;
            drain_cnt     <= 1'b0;
            pass          <= 1'b1;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            if (issue) idx <= idx + CNT_W'(1);
            // DRAIN is always two cycles: exactly the pipeline depth.
            if (state == ST_DRAIN) drain_cnt <= ~drain_cnt;
            if (mismatch) begin
                pass <= 1'b0;
                if (err_cnt == '0) first_err_idx <= idx_pipe[2];
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_addtree_driver.sv
// Directed, table-driven bench for addtree_driver with a behavioural 2-stage adder-tree pipeline.
module tb_addtree_driver;
    logic        sysclk;
    logic        rst;
    logic        start;
    logic [15:0] count;
    logic [29:0] seed;
    logic        pat_mode;
    logic [1:0]  sel_mode;
    logic        busy, done, pass;
    logic [15:0] err_cnt, first_err_idx;

    addtree_driver_if bus();

    addtree_driver #(.CNT_W(16)) dut (
        .sysclk        (sysclk),
        .rst           (rst),
        .start         (start),
        .count         (count),
        .seed          (seed),
        .pat_mode      (pat_mode),
        .sel_mode      (sel_mode),
        .pipe          (bus),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Reference pipeline: operands registered, then summed with 2*K chosen by sel.
    logic [29:0] p1, p2, p3, p4;
    logic [32:0] psum;
    int          vec_cnt, p_vec, res_vec;
    logic        vec_clr, inj_en;
    int          inj_lo, inj_hi;

    function automatic logic [32:0] kk(input logic [1:0] s);
        return (s == 2'd1) ? 33'h1579A : 33'h1FFFE;
    endfunction

    always @(posedge sysclk) begin
        p1    <= bus.in1;
        p2    <= bus.in2;
        p3    <= bus.in3;
        p4    <= bus.in4;
        p_vec <= vec_cnt;
        if (vec_clr) vec_cnt <= 0;
        else if (bus.in1 != 0 || bus.in3 != 0) vec_cnt <= vec_cnt + 1;
        psum    <= 33'(p1) + 33'(p2) + 33'(p3) + 33'(p4) + kk(bus.sel);
        res_vec <= p_vec;
    end

    assign bus.result = psum[31:0] ^ {31'b0, (inj_en && res_vec >= inj_lo && res_vec <= inj_hi)};
    assign bus.carry  = psum[32];

    int total, passed;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    endtask

    typedef struct {
        bit        pat;
        bit [1:0]  smode;
        int        cnt;
        bit [29:0] seed;
        bit        inj_en;
        int        inj_lo, inj_hi;
        bit        poke;
        bit        chk_sum;
        bit [32:0] exp_sum;
        int        exp_lat;
        bit        exp_pass;
        int        exp_err, exp_first;
    } vec_t;

    function automatic vec_t mk(bit pat, bit [1:0] sm, int cnt, bit [29:0] sd, bit ie, int lo, int hi,
                                bit pk, bit cs, bit [32:0] es, int lat, bit ep, int ee, int ef);
        vec_t v;
        v.pat = pat; v.smode = sm; v.cnt = cnt; v.seed = sd;
        v.inj_en = ie; v.inj_lo = lo; v.inj_hi = hi; v.poke = pk;
        v.chk_sum = cs; v.exp_sum = es; v.exp_lat = lat;
        v.exp_pass = ep; v.exp_err = ee; v.exp_first = ef;
        return v;
    endfunction

    task automatic launch(input vec_t v);
        @(negedge sysclk);
        pat_mode = v.pat;
        sel_mode = v.smode;
        count    = 16'(v.cnt);
        seed     = v.seed;
        inj_en   = v.inj_en;
        inj_lo   = v.inj_lo;
        inj_hi   = v.inj_hi;
        vec_clr  = 1'b1;
        start    = 1'b1;
        @(posedge sysclk);
        #1;
        start   = 1'b0;
        vec_clr = 1'b0;
    endtask

    task automatic run(input string nm, input vec_t v);
        int          lat, dwidth, op_bad, sel_bad, idx;
        bit          seen, es;
        bit [29:0]   lm, e1, e2, e3, e4;
        logic [1:0]  esel;
        launch(v);
        lm = (v.seed == 0) ? 30'd1 : v.seed;
        lat = 0; dwidth = 0; op_bad = 0; sel_bad = 0; seen = 0;
        esel = 2'b10;
        while (lat < v.cnt + 20) begin
            @(negedge sysclk);
            lat++;
            if (v.poke && lat == 2) begin start = 1'b1; count = 16'd7; end
            if (lat == 3) start = 1'b0;
            if (bus.sel !== esel) sel_bad++;
            if (lat <= v.cnt) begin
                idx = lat - 1;
                if (v.pat) begin
                    e1 = '1; e2 = '1; e3 = '1; e4 = '1;
                end else begin
                    e1 = lm;
                    e2 = {lm[14:0], lm[29:15]};
                    e3 = ~lm;
                    e4 = lm ^ 30'(idx);
                end
                case (v.smode)
                    2'd0: es = 1'b0;
                    2'd1: es = 1'b1;
                    2'd2: es = idx[0];
                    default: es = lm[0];
                endcase
                if (bus.in1 !== e1 || bus.in2 !== e2 || bus.in3 !== e3 || bus.in4 !== e4) op_bad++;
                esel = {1'b0, es};
                lm = {lm[28:0], lm[29] ^ lm[5] ^ lm[3] ^ lm[0]};
            end else begin
                if ((bus.in1 | bus.in2 | bus.in3 | bus.in4) !== 30'd0) op_bad++;
                esel = 2'b10;
            end
            if (v.chk_sum && lat == 3) chk({nm, "_sum"}, {bus.carry, bus.result}, v.exp_sum);
            if (done) begin
                dwidth++;
                if (!seen) begin
                    seen = 1;
                    chk({nm, "_done_lat"}, lat, v.exp_lat);
                end
            end else if (seen) break;
        end
        if (!seen) chk({nm, "_done_timeout"}, 0, 1);
        chk({nm, "_done_width"}, dwidth, 1);
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_pass"}, pass, v.exp_pass);
        chk({nm, "_err_cnt"}, err_cnt, v.exp_err);
        chk({nm, "_first_err"}, first_err_idx, v.exp_first);
        chk({nm, "_operands"}, op_bad, 0);
        chk({nm, "_sel"}, sel_bad, 0);
    endtask

    vec_t tbl[9];
    vec_t clean;
    int   dcnt;

    initial begin
        total = 0; passed = 0;
        rst = 1'b1; start = 1'b0; count = '0; seed = '0;
        pat_mode = 1'b0; sel_mode = 2'd0;
        vec_clr = 1'b1; inj_en = 1'b0; inj_lo = 0; inj_hi = 0;

        tbl[0] = mk(1, 0, 1,    30'h0,        0, 0, 0, 0, 1, 33'h1_0001_FFFA, 4,    1, 0, 0);
        tbl[1] = mk(1, 1, 1,    30'h0,        0, 0, 0, 0, 1, 33'h1_0001_5796, 4,    1, 0, 0);
        tbl[2] = mk(0, 2, 1000, 30'h1234567,  0, 0, 0, 0, 0, 33'h0,           1003, 1, 0, 0);
        tbl[3] = mk(0, 2, 1000, 30'h1234567,  1, 5, 5, 0, 0, 33'h0,           1003, 0, 1, 5);
        tbl[4] = mk(0, 3, 20,   30'h0,        0, 0, 0, 0, 0, 33'h0,           23,   1, 0, 0);
        tbl[5] = mk(1, 2, 10,   30'h0,        1, 3, 6, 0, 0, 33'h0,           13,   0, 4, 3);
        tbl[6] = mk(0, 0, 0,    30'h0,        0, 0, 0, 1, 0, 33'h0,           3,    1, 0, 0);
        tbl[7] = mk(0, 0, 8,    30'h0ABCDEF,  1, 7, 7, 0, 0, 33'h0,           11,   0, 1, 7);
        tbl[8] = mk(0, 1, 6,    30'h3FFFFFFF, 0, 0, 0, 1, 0, 33'h0,           9,    1, 0, 0);
        clean  = mk(0, 2, 30,   30'h2AAAAAA,  0, 0, 0, 0, 0, 33'h0,           33,   1, 0, 0);

        repeat (3) @(negedge sysclk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_err", first_err_idx, 0);
        chk("rst_ops", bus.in1 | bus.in2 | bus.in3 | bus.in4, 0);
        chk("rst_sel", bus.sel, 2'b10);
        rst = 1'b0;
        vec_clr = 1'b0;
        @(negedge sysclk);

        for (int i = 0; i < 9; i++) run($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of ISSUE, with an error already recorded.
        launch(mk(0, 2, 50, 30'h55, 1, 2, 2, 0, 0, 33'h0, 0, 0, 0, 0));
        repeat (11) @(negedge sysclk);
        chk("mid_busy_before", busy, 1);
        chk("mid_err_before", err_cnt, 1);
        chk("mid_first_before", first_err_idx, 2);
        chk("mid_in4_vec10", bus.in4 ^ bus.in1, 30'd10);
        rst = 1'b1;
        @(negedge sysclk);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_pass", pass, 0);
        chk("mid_err_cnt", err_cnt, 0);
        chk("mid_first_err", first_err_idx, 0);
        chk("mid_ops", bus.in1 | bus.in2 | bus.in3 | bus.in4, 0);
        chk("mid_sel", bus.sel, 2'b10);
        rst = 1'b0;
        inj_en = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(negedge sysclk);
            if (done || busy) dcnt++;
        end
        chk("mid_quiet", dcnt, 0);
        run("after_rst", clean);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/addtree_driver.md
ADDTREE_DRIVER -- requirements
Module: addtree_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 16, vector-count and error-count width.
REQ-002 SHALL have port sysclk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a run.
REQ-005 SHALL have port count, input, CNT_W, number of vectors; sampled on accepted start.
REQ-006 SHALL have port seed, input, 30, LFSR seed; sampled on accepted start.
REQ-007 SHALL have port pat_mode, input, 1: 0 = LFSR operands, 1 = all operands 30'h3FFFFFFF.
REQ-008 SHALL have port sel_mode, input, 2: 0 = all sel 0; 1 = all sel 1; 2 = alternate 0,1,... from 0; 3 = sel = LFSR bit 0.
REQ-009 SHALL have ports in1, in2, in3, in4, output, 30 each, operands to the adder-tree pipeline.
REQ-010 SHALL have port sel, output, 2, constant-select to the adder-tree pipeline.
REQ-011 SHALL have port result, input, 32, and port carry, input, 1, the returned pipeline sum.
REQ-012 SHALL have outputs busy (1), done (1), pass (1), err_cnt (CNT_W), first_err_idx (CNT_W).

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-014 IDLE: start=1 SHALL latch count/seed/modes and go to ISSUE, or to DRAIN if count=0; pass:=1, err_cnt:=0.
REQ-015 ISSUE SHALL drive one vector per cycle, index 0..count-1, then go to DRAIN.
REQ-016 LFSR SHALL be 30-bit Fibonacci, x^30+x^6+x^4+x+1, seed 0 replaced by 1, advancing once per issued vector.
REQ-017 LFSR operands SHALL be: in1 = L; in2 = L rotated left 15; in3 = ~L; in4 = L XOR zero-extended index.
REQ-018 sel for vector i SHALL be driven exactly one cycle after its operands, matching the pipeline's second stage.
REQ-019 Driven sel SHALL only be 0 or 1.
REQ-020 Expected value SHALL be 33-bit {carry,result} = in1+in2+in3+in4+2*K, with no truncation.
REQ-021 K SHALL be 16'hFFFF for sel 0 and 16'hABCD for sel 1.
REQ-022 Expected value and index SHALL be carried in a 2-stage valid-tagged shift register.
REQ-023 Comparison SHALL occur 2 cycles after operands are driven.
REQ-024 On mismatch: err_cnt SHALL increment (saturating at all-ones) and pass SHALL clear.
REQ-025 On the first mismatch, first_err_idx SHALL latch the vector index.
REQ-026 DRAIN SHALL last until the shift register holds no valid entry (2 cycles), then go to DONE.
REQ-027 DONE SHALL assert done for exactly one cycle; pass/err_cnt/first_err_idx SHALL hold until the next accepted start.
REQ-028 busy SHALL be 1 in ISSUE, DRAIN and DONE; start while busy SHALL be ignored.
REQ-029 Outside ISSUE, in1..in4 SHALL be 0; outside the delayed-sel slot, sel SHALL be 2'b10 (pipeline hold).
REQ-030 Comparison SHALL be enabled only for valid-tagged entries; idle-cycle results SHALL be ignored.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and clear the shift-register valid bits, including mid-run, with no done pulse.
REQ-032 rst=1 at a clock edge SHALL set in1..in4=0, sel=2'b10, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0.

Structure
REQ-033 Shared package addtree_pkg SHALL hold: operand width 30; sum width 33; constants K0=16'hFFFF, K1=16'hABCD; LFSR tap mask; sel-hold code 2'b10; FSM state enum.
REQ-034 LFSR SHALL be sub-module addtree_lfsr30 (load, advance, 30-bit state output).

Verification
REQ-035 pat_mode=1, sel_mode=0, count=1 -> expect {carry,result}=33'h1_0001_FFFA; done 4 cycles after start; pass=1.
REQ-036 pat_mode=1, sel_mode=1, count=1 -> expect 33'h1_0001_5796; pass=1.
REQ-037 pat_mode=0, sel_mode=2, seed=30'h1234567, count=1000 against a correct pipeline -> pass=1, err_cnt=0, done pulse width 1.
REQ-038 As REQ-037 with result bit 0 forced inverted for vector 5 only -> err_cnt=1, first_err_idx=5, pass=0.
REQ-039 count=0 -> done 2 cycles after the DRAIN entry cycle, pass=1, no vectors driven; start during busy -> ignored.
REQ-040 rst asserted mid-ISSUE at vector 10 -> next cycle busy=0, outputs at reset values, no done; a new start runs cleanly.
